fan_timer_ctrl: RTL and testbench
=================================

# fan_timer_ctrl

Off-delay scheduler for the fan. Arms a countdown from a button-selected preset (1/5/10/30/60 min), decrements a BCD mm:ss value once per second from an internal prescaler, and issues a one-cycle fan-off request at expiry. Sits between the debounced button layer and the fan speed controller, and drives the mm:ss digits of the FND display.

## Interface
- TICKS_PER_SEC, default 125_000_000: clk cycles per second tick. Set to a small value in simulation; legal range is ≥ 2.
- clk  in  1  system clock.
- reset_p  in  1  reset; asynchronous, active-high.
- btn_timer  in  1  one-cycle pulse; advances the preset and (re)arms the countdown.
- btn_cancel  in  1  one-cycle pulse; disarms the timer.
- fan_on  in  1  level; high while the fan is running.
- min_10, min_1, sec_10, sec_1  out  4 each  remaining time, BCD.
- preset_idx  out  3  selected preset: 0 = none, 1..5 = 01/05/10/30/60 min.
- timer_active  out  1  high in RUN.
- fan_off_req  out  1  one-cycle expiry pulse.
- warn  out  1  final-10-second warning (see Configuration).

## Operation
- State machine: IDLE, RUN, EXPIRE. The state is registered; timer_active = (state==RUN) and fan_off_req = (state==EXPIRE).
- Reset state: IDLE. All digits 0, preset_idx 0, prescaler 0, timer_active 0, fan_off_req 0, warn 0.
- IDLE, btn_timer, fan_on=1:
  - preset_idx becomes 1 and the digits load 01:00.
  - The prescaler clears and the state goes to RUN.
- IDLE, btn_timer, fan_on=0: ignored.
- RUN, btn_timer with preset_idx < 5:
  - preset_idx increments.
  - The digits load the full new preset (05:00/10:00/30:00/60:00) and the prescaler clears.
- RUN, btn_timer with preset_idx = 5: go to IDLE, preset_idx 0, digits 00:00.
- RUN, btn_cancel, or fan_on low: go to IDLE, preset_idx 0, digits 00:00, no fan_off_req.
- Prescaler in RUN: counts 0..TICKS_PER_SEC-1 and wraps. The sec tick fires on the cycle where the count is TICKS_PER_SEC-1. The prescaler holds at 0 outside RUN. Its width is $clog2(TICKS_PER_SEC).
- On a sec tick, mm:ss decrements as BCD with borrow:
  - sec_1 0→9 borrows from sec_10; sec_10 0→5 borrows from min_1; min_1 0→9 borrows from min_10.
  - No digit ever leaves its legal range (sec_10 ≤ 5, others ≤ 9).
- If a tick occurs when the remaining time is 00:01: the digits become 00:00 and the state goes to EXPIRE.
- EXPIRE lasts exactly one cycle, then the state goes to IDLE unconditionally. preset_idx clears on exit; the digits stay 00:00.
- Priority within one cycle, highest first: reset_p, btn_cancel, fan_on low, btn_timer, sec tick.
  - A reload or cancel in the tick cycle suppresses that decrement and any expiry.
- In EXPIRE, all inputs are ignored. fan_off_req still fires.

## Timing
- Load edge = the clock edge that samples btn_timer.
  - The new digits and preset_idx are visible after that edge; timer_active rises at the same edge.
- First decrement: at the TICKS_PER_SEC-th edge after the load edge. Every subsequent decrement follows TICKS_PER_SEC edges later.
- Preset of N minutes:
  - The digits reach 00:00 and the state enters EXPIRE at edge 60·N·TICKS_PER_SEC after the load edge.
  - fan_off_req is high for the following single cycle. It returns low and the state is IDLE one edge later.
- btn_cancel and fan_on low take effect at the edge that samples them; all outputs are updated after that edge.
- Asynchronous reset mid-RUN: every output returns to its reset value immediately, with no fan_off_req.

## Configuration
- FAN_TIMER_WARN_EN defined: warn is registered high while state==RUN and the remaining time is ≤ 00:10 (min_10=min_1=sec_10=0, or 00:10 exactly). It drops on any exit from RUN or on a reload above 00:10.
- FAN_TIMER_WARN_EN undefined: warn is tied to 0 and no comparator logic is built. The port is always present.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset, then btn_timer with fan_on=1 → preset_idx=1, digits 01:00, timer_active=1. At edge 4 after load the digits read 00:59; at edge 240 they read 00:00 and fan_off_req is high for exactly 1 cycle; then IDLE and preset_idx=0.
- Six btn_timer pulses, 2 cycles apart, in RUN → preset_idx 1,2,3,4,5,0 with digits 01:00, 05:00, 10:00, 30:00, 60:00, 00:00. No fan_off_req; timer_active=0 at the end.
- 60:00 preset, digits forced through 10:00 → next tick gives 09:59, with correct BCD borrow across all digits and sec_10 never exceeding 5.
- btn_cancel on the same cycle as the tick that would reach 00:00 → IDLE, digits 00:00, fan_off_req never asserted. Repeat with btn_timer instead → digits 05:00, still RUN.
- fan_on dropped mid-RUN → IDLE next edge, no fan_off_req. btn_timer with fan_on=0 in IDLE → no change.
- With FAN_TIMER_WARN_EN: warn rises at the edge where the digits become 00:10 and falls at the EXPIRE entry. Without the macro: warn stays 0 throughout the same run.

Source files
------------

// File: rtl/fan_timer_ctrl.sv
// -----------------------------------------------------------------------------
// fan_timer_ctrl
//
// Off-delay scheduler for the fan. A btn_timer pulse selects the next preset
// (01/05/10/30/60 min) and (re)arms a BCD mm:ss countdown. The countdown is
// decremented once per second, using a prescaler running on clk. At expiry a
// one-cycle fan_off_req pulse is issued to the fan speed controller.
//
// Optional feature: define FAN_TIMER_WARN_EN to build the final-10-second
// warning. When the macro is undefined, warn is tied low.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per one-second tick (>= 2)
//
// Ports
//   clk           system clock
//   reset_p       asynchronous, active-high reset
//   btn_timer     one-cycle pulse: advance preset and (re)arm
//   btn_cancel    one-cycle pulse: disarm
//   fan_on        level: fan is running; dropping it disarms
//   min_10..sec_1 remaining time, BCD digits
//   preset_idx    0 = none, 1..5 = 01/05/10/30/60 min
//   timer_active  high while counting (RUN)
//   fan_off_req   one-cycle expiry pulse (EXPIRE)
//   warn          final-10-second warning (registered)
//   state_dbg     current FSM state encoding, for observation
//
// Handshake: there is no valid/ready pair here. btn_timer and btn_cancel are
// single-cycle strobes, each sampled on the rising clk edge with no
// backpressure. fan_off_req is a single-cycle strobe the consumer must accept
// on the cycle it is high.
// -----------------------------------------------------------------------------
module fan_timer_ctrl #(
   parameter int TICKS_PER_SEC = 125_000_000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       btn_timer,
   input  logic       btn_cancel,
   input  logic       fan_on,
   output logic [3:0] min_10,
   output logic [3:0] min_1,
   output logic [3:0] sec_10,
   output logic [3:0] sec_1,
   output logic [2:0] preset_idx,
   output logic       timer_active,
   output logic       fan_off_req,
   output logic       warn,
   output logic [1:0] state_dbg
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_EXPIRE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [2:0]    preset, preset_nxt;
   // Packed as {min_10, min_1, sec_10, sec_1}.
   logic [15:0]   digits, digits_nxt;
   logic          sec_tick;

   // Full load value for each preset.
   function automatic logic [15:0] preset_digits(input logic [2:0] idx);
      logic [15:0] d;
      case (idx)
         3'd1:    d = 16'h0100;
         3'd2:    d = 16'h0500;
         3'd3:    d = 16'h1000;
         3'd4:    d = 16'h3000;
         3'd5:    d = 16'h6000;
         default: d = 16'h0000;
      endcase
      return d;
   endfunction

   // One-second BCD decrement with borrow. sec_10 wraps to 5, other digits
   // to 9. 00:00 is never decremented because 00:01 expires instead, so the
   // final min_10 borrow cannot underflow.
   function automatic logic [15:0] bcd_dec(input logic [15:0] d);
      logic [3:0] m10, m1, s10, s1;
      m10 = d[15:12];
      m1  = d[11:8];
      s10 = d[7:4];
      s1  = d[3:0];
      if (s1 != 4'd0) begin
         s1 = s1 - 4'd1;
      end else begin
         s1 = 4'd9;
         if (s10 != 4'd0) begin
            s10 = s10 - 4'd1;
         end else begin
            s10 = 4'd5;
            if (m1 != 4'd0) begin
               m1 = m1 - 4'd1;
            end else begin
               m1 = 4'd9;
               if (m10 != 4'd0) begin
                  m10 = m10 - 4'd1;
               end
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   assign sec_tick = (state == ST_RUN) && (presc == PRESC_LAST);

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state  <= ST_IDLE;
         presc  <= '0;
         preset <= 3'd0;
         digits <= 16'h0000;
      end else begin
         state  <= state_nxt;
         presc  <= presc_nxt;
         preset <= preset_nxt;
         digits <= digits_nxt;
      end
   end

   // Next-state and datapath. The prescaler defaults to 0 so that every
   // reload, cancel and non-RUN cycle restarts the second from scratch.
   always_comb begin
      state_nxt  = state;
      presc_nxt  = '0;
      preset_nxt = preset;
      digits_nxt = digits;
      case (state)
         ST_IDLE: begin
            if (btn_timer && fan_on && !btn_cancel) begin
               state_nxt  = ST_RUN;
               preset_nxt = 3'd1;
               digits_nxt = preset_digits(3'd1);
            end
         end
         ST_RUN: begin
            if (btn_cancel || !fan_on) begin
               state_nxt  = ST_IDLE;
               preset_nxt = 3'd0;
               digits_nxt = 16'h0000;
            end else if (btn_timer) begin
               if (preset < 3'd5) begin
                  preset_nxt = preset + 3'd1;
                  digits_nxt = preset_digits(preset + 3'd1);
               end else begin
                  state_nxt  = ST_IDLE;
                  preset_nxt = 3'd0;
                  digits_nxt = 16'h0000;
               end
            end else begin
               presc_nxt = sec_tick ? '0 : presc + PW'(1);
               if (sec_tick) begin
                  if (digits == 16'h0001) begin
                     digits_nxt = 16'h0000;
                     state_nxt  = ST_EXPIRE;
                  end else begin
                     digits_nxt = bcd_dec(digits);
                  end
               end
            end
         end
         ST_EXPIRE: begin
            // Inputs are ignored for this single cycle.
            state_nxt  = ST_IDLE;
            preset_nxt = 3'd0;
            digits_nxt = 16'h0000;
         end
         default: begin
            state_nxt  = ST_IDLE;
            preset_nxt = 3'd0;
            digits_nxt = 16'h0000;
         end
      endcase
   end

`ifdef FAN_TIMER_WARN_EN
   // Registered from next-state values so warn changes on the same edge as
   // the digits it describes: high in RUN at or below 00:10.
   logic warn_q;
   logic warn_nxt;

   always_comb begin
      warn_nxt = (state_nxt == ST_RUN) &&
                 (digits_nxt[15:8] == 8'h00) &&
                 ((digits_nxt[7:4] == 4'd0) || (digits_nxt[7:0] == 8'h10));
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_nxt;
      end
   end

   assign warn = warn_q;
`else
   assign warn = 1'b0;
`endif

   assign min_10       = digits[15:12];
   assign min_1        = digits[11:8];
   assign sec_10       = digits[7:4];
   assign sec_1        = digits[3:0];
   assign preset_idx   = preset;
   assign timer_active = (state == ST_RUN);
   assign fan_off_req  = (state == ST_EXPIRE);
   assign state_dbg    = state;

endmodule

// File: tb/tb_fan_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_timer_ctrl
//
// Bench for fan_timer_ctrl with TICKS_PER_SEC = 4. Expected expiry cycles are
// queued when a countdown is armed and popped when fan_off_req is observed.
// Direct checks cover reset, preset cycling, BCD borrow, cancel/reload on the
// expiry tick, fan_on drop, async reset and the warn output.
// -----------------------------------------------------------------------------
module tb_fan_timer_ctrl;

   localparam int TPS = 4;
`ifdef FAN_TIMER_WARN_EN
   localparam logic WARN_EN = 1'b1;
`else
   localparam logic WARN_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       reset_p;
   logic       btn_timer;
   logic       btn_cancel;
   logic       fan_on;
   logic [3:0] min_10, min_1, sec_10, sec_1;
   logic [2:0] preset_idx;
   logic       timer_active;
   logic       fan_off_req;
   logic       warn;
   logic [1:0] state_dbg;
   logic [15:0] digits;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int bad_digit = 0;
   int bad_warn  = 0;
   int last_load = 0;

   logic [31:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign digits = {min_10, min_1, sec_10, sec_1};

   fan_timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .btn_timer    (btn_timer),
      .btn_cancel   (btn_cancel),
      .fan_on       (fan_on),
      .min_10       (min_10),
      .min_1        (min_1),
      .sec_10       (sec_10),
      .sec_1        (sec_1),
      .preset_idx   (preset_idx),
      .timer_active (timer_active),
      .fan_off_req  (fan_off_req),
      .warn         (warn),
      .state_dbg    (state_dbg)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every fan_off_req pulse must match the next queued cycle.
   always @(negedge clk) begin
      if (fan_off_req) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_off_req", cyc, 32'hFFFF_FFFF);
         end else begin
            check_val("off_req_cycle", cyc, exp_q.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   // All drivers assume they start #1 after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_timer();
      btn_timer = 1'b1;
      @(posedge clk);
      #1;
      btn_timer = 1'b0;
      last_load = cyc;
   endtask

   task automatic pulse_cancel();
      btn_cancel = 1'b1;
      @(posedge clk);
      #1;
      btn_cancel = 1'b0;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) begin
         step(1);
         if (sec_10 > 4'd5 || sec_1 > 4'd9 || min_1 > 4'd9 || min_10 > 4'd6)
            bad_digit++;
         if (!WARN_EN && warn) bad_warn++;
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_active"}, timer_active, 1'b0);
      check_val({tag, "_preset"}, preset_idx, 3'd0);
      check_val({tag, "_digits"}, digits, 16'h0000);
      check_val({tag, "_state"}, state_dbg, 2'd0);
   endtask

   logic [15:0] preset_tab [0:5];
   logic [2:0]  idx_tab    [0:5];

   // ---------------- stimulus ----------------
   initial begin
      preset_tab[0] = 16'h0100; idx_tab[0] = 3'd1;
      preset_tab[1] = 16'h0500; idx_tab[1] = 3'd2;
      preset_tab[2] = 16'h1000; idx_tab[2] = 3'd3;
      preset_tab[3] = 16'h3000; idx_tab[3] = 3'd4;
      preset_tab[4] = 16'h6000; idx_tab[4] = 3'd5;
      preset_tab[5] = 16'h0000; idx_tab[5] = 3'd0;

      reset_p    = 1'b1;
      btn_timer  = 1'b0;
      btn_cancel = 1'b0;
      fan_on     = 1'b0;
      step(3);
      check_idle("reset");
      check_val("reset_off_req", fan_off_req, 1'b0);
      check_val("reset_warn", warn, 1'b0);
      reset_p = 1'b0;
      step(2);

      // 1) one-minute countdown to expiry
      fan_on = 1'b1;
      pulse_timer();
      exp_q.push_back(last_load + 240);
      check_val("t1_preset", preset_idx, 3'd1);
      check_val("t1_digits", digits, 16'h0100);
      check_val("t1_active", timer_active, 1'b1);
      run_to(last_load + 3);
      check_val("t1_edge3", digits, 16'h0100);
      run_to(last_load + 4);
      check_val("t1_edge4", digits, 16'h0059);
      run_to(last_load + 239);
      check_val("t1_edge239", digits, 16'h0001);
      run_to(last_load + 240);
      check_val("t1_end_digits", digits, 16'h0000);
      check_val("t1_off_req", fan_off_req, 1'b1);
      check_val("t1_preset_exp", preset_idx, 3'd1);
      step(1);
      check_val("t1_off_req_low", fan_off_req, 1'b0);
      check_idle("t1_after");

      // 2) six pulses, 2 cycles apart
      for (int i = 0; i < 6; i++) begin
         pulse_timer();
         check_val($sformatf("t2_preset%0d", i), preset_idx, idx_tab[i]);
         check_val($sformatf("t2_digits%0d", i), digits, preset_tab[i]);
         step(1);
      end
      check_val("t2_active", timer_active, 1'b0);

      // 3) 60:00 down through 10:00, warn window, expiry
      for (int i = 0; i < 5; i++) pulse_timer();
      check_val("t3_load", digits, 16'h6000);
      exp_q.push_back(last_load + 14400);
      run_to(last_load + 12000);
      check_val("t3_1000", digits, 16'h1000);
      run_to(last_load + 12004);
      check_val("t3_0959", digits, 16'h0959);
      run_to(last_load + 14356);
      check_val("t3_0011", digits, 16'h0011);
      check_val("t3_warn_0011", warn, 1'b0);
      run_to(last_load + 14359);
      check_val("t3_warn_pre", warn, 1'b0);
      run_to(last_load + 14360);
      check_val("t3_0010", digits, 16'h0010);
      check_val("t3_warn_0010", warn, WARN_EN);
      run_to(last_load + 14399);
      check_val("t3_warn_0001", warn, WARN_EN);
      run_to(last_load + 14400);
      check_val("t3_off_req", fan_off_req, 1'b1);
      check_val("t3_warn_exp", warn, 1'b0);
      step(1);
      check_idle("t3_after");
      check_val("t3_digit_range", bad_digit, 0);
      check_val("t3_warn_tied", bad_warn, 0);

      // 4a) cancel on the tick that would reach 00:00
      pulse_timer();
      run_to(last_load + 239);
      check_val("t4_pre", digits, 16'h0001);
      pulse_cancel();
      check_idle("t4_cancel");
      check_val("t4_no_off", fan_off_req, 1'b0);
      step(2);
      // 4b) reload on the same tick instead
      pulse_timer();
      run_to(last_load + 239);
      pulse_timer();
      check_val("t4_reload_digits", digits, 16'h0500);
      check_val("t4_reload_preset", preset_idx, 3'd2);
      check_val("t4_reload_active", timer_active, 1'b1);
      step(1);
      check_val("t4_reload_hold", digits, 16'h0500);
      pulse_cancel();
      check_idle("t4_cleanup");

      // 5) fan_on dropped mid-RUN, then btn_timer with fan off
      pulse_timer();
      step(50);
      fan_on = 1'b0;
      step(1);
      check_idle("t5_drop");
      pulse_timer();
      check_idle("t5_ignored");
      step(2);

      // 6) asynchronous reset mid-RUN
      fan_on = 1'b1;
      pulse_timer();
      step(20);
      check_val("t6_running", timer_active, 1'b1);
      reset_p = 1'b1;
      #1;
      check_idle("t6_async");
      check_val("t6_off_req", fan_off_req, 1'b0);
      step(1);
      reset_p = 1'b0;
      step(2);

      check_val("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
